io_dma_buffer: RTL and testbench

IO_DMA_BUFFER -- requirements
Module: io_dma_buffer

---
 rtl/io_dma_buffer.sv | 169 ++++++++++++++++
 tb/tb_io_dma_buffer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_dma_buffer.sv
// Circular DMA staging buffer between a streaming device producer and a bus-side
// DMA engine, with status/control registers and an interrupt-request FSM.
module io_dma_buffer #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 32,
    parameter int IRQ_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       dev_valid,
    input  logic [DATA_W-1:0]          dev_data,
    output logic                       dev_ready,
    input  logic                       ack,
    input  logic                       io_write,
    input  logic                       cs,
    input  logic [1:0]                 reg_addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       rdata_valid,
    output logic                       gpio,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] THRESH = CW'(IRQ_THRESH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              collision_q, collision_d;
    logic              irq_en_q, irq_en_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              gpio_q, gpio_d;
    state_t            state_q, state_d;

    logic              full, empty;
    logic              push_req, pop_req, push, pop;
    logic              reg_rd, reg_wr;
    logic [DATA_W-1:0] push_data;
    logic [DATA_W-1:0] reg_val;

    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    assign dev_ready = ~full;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign gpio        = gpio_q;
    assign count       = count_q;

    // The device always owns the write port when it is offering; a bus word
    // arriving in the same cycle is the one that gets dropped.
    always_comb begin
        pop_req   = ack & ~io_write;
        push_req  = dev_valid | (ack & io_write);
        pop       = pop_req & ~empty;
        push      = push_req & (~full | pop);
        push_data = dev_valid ? dev_data : wdata;
        reg_rd    = cs & ~ack & ~io_write;
        reg_wr    = cs & ~ack & io_write;
    end

    always_comb begin
        reg_val = '0;
        case (reg_addr)
            2'd0:    reg_val = DATA_W'({collision_q, underflow_q, overflow_q, full, empty, count_q});
            2'd1:    reg_val = DATA_W'(irq_en_q);
            2'd2:    reg_val = '0;
            default: reg_val = DATA_W'(DEPTH);
        endcase
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        underflow_d   = underflow_q;
        collision_d   = collision_q;
        irq_en_d      = irq_en_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (pop) begin
            rdata_d       = mem[rd_ptr_q];
            rdata_valid_d = 1'b1;
        end else if (reg_rd) begin
            rdata_d       = reg_val;
            rdata_valid_d = 1'b1;
        end

        if (reg_wr && reg_addr == 2'd1) irq_en_d = wdata[0];
        if (reg_wr && reg_addr == 2'd2) begin
            if (wdata[0]) overflow_d  = 1'b0;
            if (wdata[1]) underflow_d = 1'b0;
            if (wdata[2]) collision_d = 1'b0;
        end

        // A new event in the same cycle as a software clear must not be lost.
        if (push_req && full && !pop)       overflow_d  = 1'b1;
        if (pop_req && empty)               underflow_d = 1'b1;
        if (ack && io_write && dev_valid)   collision_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (irq_en_q && count_q >= THRESH) state_d = REQ;
            REQ: begin
                if (!irq_en_q)       state_d = IDLE;
                else if (ack)        state_d = (count_d == '0) ? IDLE : XFER;
            end
            XFER: if (count_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        gpio_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            collision_q   <= 1'b0;
            irq_en_q      <= 1'b1;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            gpio_q        <= 1'b0;
            state_q       <= IDLE;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            collision_q   <= collision_d;
            irq_en_q      <= irq_en_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            gpio_q        <= gpio_d;
            state_q       <= state_d;
        end
    end

    // Storage is deliberately not reset; occupancy tracking makes stale words invisible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: tb/tb_io_dma_buffer.sv
// Self-checking bench for io_dma_buffer: directed vector table, multi-cycle corner
// sequences and a randomized run against a queue-based reference model.
module tb_io_dma_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int THRESH = 1;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              dev_valid = 1'b0;
    logic [DATA_W-1:0] dev_data = '0;
    logic              dev_ready;
    logic              ack = 1'b0;
    logic              io_write = 1'b0;
    logic              cs = 1'b0;
    logic [1:0]        reg_addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              gpio;
    logic [CW-1:0]     count;

    always #5 clk = ~clk;

    io_dma_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IRQ_THRESH(THRESH)) dut (
        .clk(clk), .rst_n(rst_n), .dev_valid(dev_valid), .dev_data(dev_data),
        .dev_ready(dev_ready), .ack(ack), .io_write(io_write), .cs(cs),
        .reg_addr(reg_addr), .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
        .gpio(gpio), .count(count)
    );

    int tests  = 0;
    int errors = 0;

    // Reference model state
    logic [DATA_W-1:0] q[$];
    bit                m_ovf, m_udf, m_col, m_irq_en, m_valid;
    logic [DATA_W-1:0] m_rdata;
    int                m_phase;

    typedef struct {
        bit                dv;
        logic [DATA_W-1:0] dd;
        bit                a;
        bit                iow;
        bit                c;
        logic [1:0]        ra;
        logic [DATA_W-1:0] wd;
        bit                ev;
        logic [DATA_W-1:0] er;
        int                ec;
        bit                eg;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] reg_value(input logic [1:0] a);
        logic [DATA_W-1:0] v;
        int n;
        n = q.size();
        v = '0;
        case (a)
            2'd0: begin
                v = DATA_W'(n);
                v[CW]   = (n == 0);
                v[CW+1] = (n == DEPTH);
                v[CW+2] = m_ovf;
                v[CW+3] = m_udf;
                v[CW+4] = m_col;
            end
            2'd1:    v = DATA_W'(m_irq_en);
            2'd2:    v = '0;
            default: v = DATA_W'(DEPTH);
        endcase
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_udf = 0; m_col = 0; m_irq_en = 1;
        m_valid = 0; m_rdata = '0; m_phase = 0;
    endtask

    // One clock of behaviour computed from the pre-edge state.
    task automatic model_step(input bit dv, input logic [DATA_W-1:0] dd, input bit a, input bit iow,
                              input bit c, input logic [1:0] ra, input logic [DATA_W-1:0] wd);
        int pre_n, new_n;
        bit pre_irq, popped;
        logic [DATA_W-1:0] rv;
        pre_n   = q.size();
        pre_irq = m_irq_en;
        rv      = reg_value(ra);
        popped  = 0;
        if (a && !iow) begin
            if (pre_n > 0) begin
                m_rdata = q.pop_front();
                m_valid = 1;
                popped  = 1;
            end else begin
                m_valid = 0;
                m_udf   = 1;
            end
        end else if (c && !a && !iow) begin
            m_rdata = rv;
            m_valid = 1;
        end else begin
            m_valid = 0;
        end
        if (c && !a && iow) begin
            if (ra == 2'd1) m_irq_en = wd[0];
            if (ra == 2'd2) begin
                if (wd[0]) m_ovf = 0;
                if (wd[1]) m_udf = 0;
                if (wd[2]) m_col = 0;
            end
        end
        if (dv || (a && iow)) begin
            if (pre_n < DEPTH || popped) q.push_back(dv ? dd : wd);
            else m_ovf = 1;
        end
        if (a && iow && dv) m_col = 1;
        new_n = q.size();
        case (m_phase)
            0: if (pre_irq && pre_n >= THRESH) m_phase = 1;
            1: begin
                if (!pre_irq) m_phase = 0;
                else if (a)   m_phase = (new_n == 0) ? 0 : 2;
            end
            default: if (new_n == 0) m_phase = 0;
        endcase
    endtask

    task automatic check_output();
        check("rdata_valid", rdata_valid, m_valid);
        check("rdata", rdata, m_rdata);
        check("count", count, q.size());
        check("dev_ready", dev_ready, q.size() < DEPTH);
        check("gpio", gpio, m_phase != 0);
    endtask

    task automatic apply_stimulus(input bit dv, input logic [DATA_W-1:0] dd, input bit a, input bit iow,
                                  input bit c, input logic [1:0] ra, input logic [DATA_W-1:0] wd);
        dev_valid = dv; dev_data = dd; ack = a; io_write = iow;
        cs = c; reg_addr = ra; wdata = wd;
        model_step(dv, dd, a, iow, c, ra, wd);
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic idle_inputs();
        dev_valid = 0; dev_data = '0; ack = 0; io_write = 0;
        cs = 0; reg_addr = '0; wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        #1;
        check_output();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        logic [DATA_W-1:0] exp_word;
        logic [DATA_W-1:0] empty_status;

        tbl[0]  = '{1, 32'h11, 0, 0, 0, 2'd0, 32'h0,   0, 32'h0,   1, 0};
        tbl[1]  = '{1, 32'h22, 0, 0, 0, 2'd0, 32'h0,   0, 32'h0,   2, 1};
        tbl[2]  = '{1, 32'h33, 0, 0, 0, 2'd0, 32'h0,   0, 32'h0,   3, 1};
        tbl[3]  = '{0, 32'h0,  1, 0, 0, 2'd0, 32'h0,   1, 32'h11,  2, 1};
        tbl[4]  = '{0, 32'h0,  1, 0, 0, 2'd0, 32'h0,   1, 32'h22,  1, 1};
        tbl[5]  = '{0, 32'h0,  1, 0, 0, 2'd0, 32'h0,   1, 32'h33,  0, 0};
        tbl[6]  = '{0, 32'h0,  0, 0, 1, 2'd3, 32'h0,   1, 32'h8,   0, 0};
        tbl[7]  = '{0, 32'h0,  1, 0, 0, 2'd0, 32'h0,   0, 32'h8,   0, 0};
        tbl[8]  = '{0, 32'h0,  0, 0, 1, 2'd0, 32'h0,   1, 32'h90,  0, 0};
        tbl[9]  = '{0, 32'h0,  0, 1, 1, 2'd2, 32'h2,   0, 32'h90,  0, 0};
        tbl[10] = '{0, 32'h0,  0, 0, 1, 2'd0, 32'h0,   1, 32'h10,  0, 0};
        tbl[11] = '{1, 32'h5A, 1, 1, 0, 2'd0, 32'hA5,  0, 32'h10,  1, 0};
        tbl[12] = '{0, 32'h0,  0, 0, 1, 2'd0, 32'h0,   1, 32'h101, 1, 1};
        tbl[13] = '{0, 32'h0,  1, 0, 0, 2'd0, 32'h0,   1, 32'h5A,  0, 0};
        tbl[14] = '{0, 32'h0,  0, 0, 1, 2'd1, 32'h0,   1, 32'h1,   0, 0};
        tbl[15] = '{0, 32'h0,  0, 0, 1, 2'd2, 32'h0,   1, 32'h0,   0, 0};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(tbl[i].dv, tbl[i].dd, tbl[i].a, tbl[i].iow, tbl[i].c, tbl[i].ra, tbl[i].wd);
            check($sformatf("vec%0d_valid", i), rdata_valid, tbl[i].ev);
            check($sformatf("vec%0d_rdata", i), rdata, tbl[i].er);
            check($sformatf("vec%0d_count", i), count, tbl[i].ec);
            check($sformatf("vec%0d_gpio", i), gpio, tbl[i].eg);
        end

        // Overflow on a full buffer, then software clear
        do_reset();
        for (int i = 0; i < DEPTH; i++) apply_stimulus(1, 32'h100 + i, 0, 0, 0, 2'd0, 32'h0);
        check("full_dev_ready", dev_ready, 0);
        check("full_count", count, DEPTH);
        apply_stimulus(1, 32'hDEAD, 0, 0, 0, 2'd0, 32'h0);
        check("ovf_count", count, DEPTH);
        apply_stimulus(0, 32'h0, 0, 0, 1, 2'd0, 32'h0);
        check("ovf_bit_set", rdata[CW+2], 1);
        apply_stimulus(0, 32'h0, 0, 1, 1, 2'd2, 32'h1);
        apply_stimulus(0, 32'h0, 0, 0, 1, 2'd0, 32'h0);
        check("ovf_bit_clr", rdata[CW+2], 0);

        // Push and pop together while full, across the pointer wrap
        for (int i = 0; i < DEPTH + 2; i++) begin
            apply_stimulus(1, 32'h200 + i, 1, 0, 0, 2'd0, 32'h0);
            exp_word = (i < DEPTH) ? 32'(32'h100 + i) : 32'(32'h200 + i - DEPTH);
            check("wrap_count", count, DEPTH);
            check("wrap_order", rdata, exp_word);
        end
        for (int i = 0; i < DEPTH; i++) apply_stimulus(0, 32'h0, 1, 0, 0, 2'd0, 32'h0);

        // Asynchronous reset in the middle of a transfer
        do_reset();
        for (int i = 0; i < 6; i++) apply_stimulus(1, 32'h300 + i, 0, 0, 0, 2'd0, 32'h0);
        apply_stimulus(0, 32'h0, 1, 0, 0, 2'd0, 32'h0);
        check("xfer_gpio", gpio, 1);
        check("xfer_count", count, 5);
        @(posedge clk);
        #3;
        rst_n = 0;
        idle_inputs();
        model_reset();
        #1;
        check("async_gpio", gpio, 0);
        check("async_count", count, 0);
        check("async_valid", rdata_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        empty_status = '0;
        empty_status[CW] = 1'b1;
        apply_stimulus(0, 32'h0, 0, 0, 1, 2'd0, 32'h0);
        check("post_rst_status", rdata, empty_status);
        apply_stimulus(0, 32'h0, 1, 0, 0, 2'd0, 32'h0);
        check("post_rst_pop_valid", rdata_valid, 0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit dv, a, iow, c;
            logic [1:0] ra;
            logic [DATA_W-1:0] wd;
            int push_bias;
            push_bias = (i % 600 < 300) ? 2 : 5;
            dv  = ($urandom % push_bias) == 0;
            a   = ($urandom % 3) == 0;
            iow = ($urandom % 3) == 0;
            c   = ($urandom % 4) == 0;
            ra  = 2'($urandom % 4);
            wd  = $urandom;
            if (c && ra == 2'd1) wd[0] = ($urandom % 4) != 0;
            apply_stimulus(dv, $urandom, a, iow, c, ra, wd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
